// File: rtl/measure_result_calc.sv
// Converts captured period/high-time sums into frequency (Hz) and duty (per-mille)
// using one shared 32-cycle restoring divider, reporting results with a valid strobe.
module measure_result_calc #(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned AVG_CYCLES = 8,
   parameter int          PERIOD_W   = 26,
   parameter int          HIGH_W     = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [PERIOD_W-1:0] period_sum,
   input  logic [HIGH_W-1:0]   high_sum,
   output logic                busy,
   output logic                valid,
   output logic [31:0]         freq_hz,
   output logic [9:0]          duty_pm,
   output logic                err
);

   localparam logic [63:0] DIVIDEND_PROD = 64'(CLK_FREQ) * 64'(AVG_CYCLES);
   localparam logic [31:0] FREQ_DIVIDEND = DIVIDEND_PROD[31:0];

   if (DIVIDEND_PROD >= 64'h1_0000_0000) begin : g_param_check
      $error("CLK_FREQ*AVG_CYCLES must be below 2^32");
   end

   typedef enum logic [1:0] {IDLE, DIV_FREQ, DIV_DUTY, DONE} state_t;

   state_t              state;
   state_t              state_next;
   logic [PERIOD_W-1:0] period_q;
   logic [HIGH_W-1:0]   high_q;
   logic                err_q;
   logic [31:0]         rem;
   logic [31:0]         dvd;
   logic [31:0]         quo;
   logic [31:0]         freq_q;
   logic [4:0]          cnt;

   logic [31:0]         divisor;
   logic [32:0]         rem_shift;
   logic                q_bit;
   logic [31:0]         rem_next;
   logic [31:0]         quo_next;
   logic [31:0]         duty_dividend;
   logic                last_step;

   // One restoring step: the 33-bit shifted remainder is compared to the divisor.
   always_comb begin
      divisor       = 32'(period_q);
      rem_shift     = {rem, dvd[31]};
      q_bit         = (rem_shift >= 33'(divisor));
      rem_next      = q_bit ? 32'(rem_shift - 33'(divisor)) : rem_shift[31:0];
      quo_next      = 32'({quo, q_bit});
      duty_dividend = (32'(high_q) << 10) - (32'(high_q) << 4) - (32'(high_q) << 3);
      last_step     = (cnt == 5'd31);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (start) state_next = (period_sum == '0) ? DONE : DIV_FREQ;
         DIV_FREQ: if (last_step) state_next = DIV_DUTY;
         DIV_DUTY: if (last_step) state_next = DONE;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   assign busy  = (state == DIV_FREQ) || (state == DIV_DUTY);
   assign valid = (state == DONE);

   // Result registers are loaded only on entry to DONE, so partial quotients never leak.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_q <= '0;
         high_q   <= '0;
         err_q    <= 1'b0;
         rem      <= '0;
         dvd      <= '0;
         quo      <= '0;
         freq_q   <= '0;
         cnt      <= '0;
         freq_hz  <= '0;
         duty_pm  <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  period_q <= period_sum;
                  high_q   <= high_sum;
                  err_q    <= (period_sum == '0) || (32'(high_sum) > 32'(period_sum));
                  rem      <= '0;
                  quo      <= '0;
                  cnt      <= '0;
                  dvd      <= FREQ_DIVIDEND;
                  if (period_sum == '0) begin
                     freq_hz <= '0;
                     duty_pm <= '0;
                     err     <= 1'b1;
                  end
               end
            end
            DIV_FREQ: begin
               cnt <= cnt + 5'd1;
               if (last_step) begin
                  freq_q <= quo_next;
                  rem    <= '0;
                  quo    <= '0;
                  dvd    <= duty_dividend;
               end else begin
                  rem <= rem_next;
                  quo <= quo_next;
                  dvd <= dvd << 1;
               end
            end
            DIV_DUTY: begin
               cnt <= cnt + 5'd1;
               rem <= rem_next;
               quo <= quo_next;
               dvd <= dvd << 1;
               if (last_step) begin
                  freq_hz <= freq_q;
                  duty_pm <= (quo_next > 32'd1000) ? 10'd1000 : quo_next[9:0];
                  err     <= err_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/measure_result_calc.md
Name: measure_result_calc

Overview:
Downstream stage of signal_measure_ctrl. On that block's finish pulse, it captures the accumulated period and high-time sums, which are in clk cycles over AVG_CYCLES input periods. It then converts them to input frequency in Hz and duty cycle in per-mille using one shared iterative restoring divider. Results feed the debugger's register/display layer through a one-cycle valid strobe.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
AVG_CYCLES, 8, number of input periods summed upstream. CLK_FREQ*AVG_CYCLES must be < 2^32; elaboration fails otherwise.
PERIOD_W, 26, width of period_sum.
HIGH_W, 20, width of high_sum.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  one-cycle capture strobe, driven from the upstream finish.
period_sum  input  PERIOD_W  summed period in clk cycles; sampled only when start is accepted.
high_sum  input  HIGH_W  summed high time in clk cycles; sampled only when start is accepted.
busy  output  1  high while a conversion is in progress.
valid  output  1  one-cycle pulse; results are updated in the same cycle.
freq_hz  output  32  (CLK_FREQ*AVG_CYCLES)/period_sum, truncated.
duty_pm  output  10  (high_sum*1000)/period_sum, truncated, clamped to 1000.
err  output  1  status of the last conversion: period_sum==0 or high_sum>period_sum.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: busy=0, valid=0, freq_hz=0, duty_pm=0, err=0. The FSM goes to IDLE and the divider registers clear.
- FSM states: IDLE, DIV_FREQ, DIV_DUTY, DONE.
- IDLE:
  - start=1 in cycle T latches period_sum and high_sum.
  - If the latched period is 0: go to DONE. Quotients are forced to 0 and err is set, so valid fires at T+1.
  - Otherwise: go to DIV_FREQ.
- DIV_FREQ:
  - Dividend = CLK_FREQ*AVG_CYCLES, a 32-bit constant. Divisor = latched period, zero-extended to 32 bits.
  - Restoring division, one quotient bit per cycle, MSB first, 32 cycles (T+1..T+32). A 33-bit partial remainder is required.
  - After the 32nd cycle, the quotient goes to a freq holding register. Then go to DIV_DUTY.
- DIV_DUTY:
  - Dividend = latched high*1000, computed as (high<<10)-(high<<4)-(high<<3), 32 bits wide.
  - Same divisor and same divider hardware, 32 cycles (T+33..T+64).
  - Quotient above 1000 is clamped to 1000. Then go to DONE.
- DONE (T+65 on the normal path):
  - freq_hz, duty_pm and err are updated.
  - valid=1 for exactly this cycle, busy=0 in this cycle.
  - Return to IDLE next cycle.
- busy timing: busy=1 from T+1 through T+64 on the normal path. busy=0 in IDLE and DONE.
- Fixed latency: start-to-valid is 65 cycles on the normal path and 1 cycle on the zero-period path, independent of data values.
- err:
  - 1 if period==0.
  - 1 if high>period; duty is clamped to 1000 and freq is still computed normally.
  - Else 0.
  - Updated only at DONE.
- Outputs hold their last values between valid pulses. No partial results are ever visible.
- start while busy or in DONE is ignored, not queued. Inputs changing after capture have no effect.
- Rounding: truncation only, no round-to-nearest.
- Reset asserted mid-conversion aborts immediately: all outputs go to their reset values and no valid is emitted. The first start after reset release is accepted normally.
- Back-to-back: a start in the cycle after DONE (i.e. in IDLE) is accepted.

Test Plan:
- 500 kHz, 40% (100-clk period, 40-clk high): period_sum=800, high_sum=320, start pulse -> valid exactly 65 cycles later; freq_hz=500000, duty_pm=400, err=0; busy high for 64 cycles.
- 833 kHz, 55% (60-clk period, 33-clk high): period_sum=480, high_sum=264 -> freq_hz=833333 (truncated), duty_pm=550, err=0.
- period_sum=0, high_sum=5 -> valid at T+1, freq_hz=0, duty_pm=0, err=1, no busy cycles. A following normal start (800/320) -> err returns to 0 with correct results.
- period_sum=100, high_sum=150 -> freq_hz=4000000, duty_pm=1000 (clamped), err=1. Also edge values period_sum=1, high_sum=0 -> freq_hz=400000000, duty_pm=0, err=0.
- Second start at T+10 with different data during a busy conversion -> ignored; the single valid at T+65 carries the first data (500000/400). rst asserted at T+30 -> outputs zero immediately, no valid pulse; a new start after release completes normally.
- Capture timing: start with 800/320, then change the inputs to 480/264 at T+1 -> results still 500000/400. Outputs hold unchanged for 100+ cycles after valid while the inputs toggle.
